// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity modes and oversampling factor
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OVS = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serializes one byte per request into start, LSB-first data,
// optional parity and stop bits, timed by the shared 16x oversampling tick.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);
    import uart_pkg::*;

    localparam logic [4:0] OVS_LAST = 5'(OVS - 1);
    localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST   = 3'(DBIT - 1);

    state_t     state_reg, state_next;
    logic [4:0] s_reg, s_next;
    logic [2:0] n_reg, n_next;
    logic [7:0] b_reg, b_next;
    logic       p_reg, p_next;
    logic       tx_reg, tx_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        p_next       = p_reg;
        tx_done_tick = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    b_next     = din;
                    s_next     = '0;
                    p_next     = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == OVS_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == OVS_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        p_next = p_reg ^ b_reg[0];
                        if (n_reg == N_LAST)
                            state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        else
                            n_next = n_reg + 3'd1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (s_tick) begin
                    if (s_reg == OVS_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == SB_LAST) begin
                        tx_done_tick = 1'b1;
                        s_next       = '0;
                        state_next   = IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state so tx changes on the same
    // edge as the state, keeping every bit exactly aligned to its state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            IDLE:             tx_next = 1'b1;
            START:            tx_next = 1'b0;
            DATA:             tx_next = b_next[0];
            uart_pkg::PARITY: tx_next = (PARITY == PAR_ODD) ? ~p_next : p_next;
            STOP:             tx_next = 1'b1;
            default:          tx_next = 1'b1;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state_reg != IDLE);

endmodule
